// File: rtl/flash_io_pkg.sv
// rtl/flash_io_pkg.sv - shared opcodes, SPI commands and state encoding for the flash boot sequencer
package flash_io_pkg;

  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_WAIT  = 8'h02;

  localparam logic [7:0] CMD_WAKE = 8'hAB;
  localparam logic [7:0] CMD_READ = 8'h03;

  localparam logic [5:0] BITS_WAKE  = 6'd8;
  localparam logic [5:0] BITS_FETCH = 6'd16;
  localparam logic [5:0] BITS_CMD   = 6'd32;

  localparam logic [37:0] PAD_OEB = 38'h3F_FFFF_FF00;

  typedef enum logic [2:0] {
    ST_WAKE,
    ST_GAP,
    ST_CMD,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT,
    ST_HALT,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - CLK_DIV-paced SPI mode-0 shifter, MSB first
module spi_shift_engine
  import flash_io_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  len,
  input  logic [31:0] tx,
  output logic        busy,
  output logic        done,
  output logic        rx_last,
  output logic [15:0] rx,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt;
  logic [5:0]  bits_left;
  logic [31:0] tx_sh;

  // Each bit: CLK_DIV cycles low with mosi stable, sample miso on the rising edge,
  // CLK_DIV cycles high, then mosi moves on with the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_last   <= 1'b0;
      rx        <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sh     <= '0;
    end else begin
      done    <= 1'b0;
      rx_last <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy      <= 1'b1;
          div_cnt   <= '0;
          bits_left <= len;
          rx        <= '0;
          sclk      <= 1'b0;
          mosi      <= tx[31];
          tx_sh     <= {tx[30:0], 1'b0};
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk    <= 1'b1;
          rx      <= {rx[14:0], miso};
          rx_last <= (bits_left == 6'd1);
        end else begin
          sclk <= 1'b0;
          if (bits_left == 6'd1) begin
            busy <= 1'b0;
            done <= 1'b1;
            mosi <= 1'b0;
          end else begin
            bits_left <= bits_left - 6'd1;
            mosi      <= tx_sh[31];
            tx_sh     <= {tx_sh[30:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/flash_io_sequencer.sv
// rtl/flash_io_sequencer.sv - boots from SPI flash and runs a WRITE/WAIT/HALT byte program onto mprj_io[7:0]
module flash_io_sequencer
  import flash_io_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int WAKE_GAP  = 16,
  parameter int WAIT_UNIT = 256
) (
  input  logic        clock,
  input  logic        resetb,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1,
  output logic [37:0] mprj_io_out,
  output logic [37:0] mprj_io_oeb,
  output logic        done,
  output logic        fault
);

  localparam logic [31:0] GAP_LAST    = 32'(WAKE_GAP - 1);
  localparam logic [31:0] WAIT_UNIT_W = 32'(WAIT_UNIT);

  state_t      state, state_nx;
  logic        launched;
  logic [31:0] cnt;
  logic [15:0] instr;
  logic [7:0]  pad;
  logic        csb_nx;

  logic        eng_start, eng_busy, eng_done, eng_rx_last;
  logic [5:0]  eng_len;
  logic [31:0] eng_tx;
  logic [15:0] eng_rx;

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk     (clock),
    .rst_n   (resetb),
    .start   (eng_start),
    .len     (eng_len),
    .tx      (eng_tx),
    .busy    (eng_busy),
    .done    (eng_done),
    .rx_last (eng_rx_last),
    .rx      (eng_rx),
    .sclk    (flash_clk),
    .mosi    (flash_io0),
    .miso    (flash_io1)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= ST_WAKE;
    else         state <= state_nx;
  end

  // EXEC holds until the engine has finished the last high phase so csb never
  // rises with flash_clk high.
  always_comb begin
    state_nx = state;
    case (state)
      ST_WAKE:  if (eng_done) state_nx = ST_GAP;
      ST_GAP:   if (cnt == GAP_LAST) state_nx = ST_CMD;
      ST_CMD:   if (eng_done) state_nx = ST_FETCH;
      ST_FETCH: if (eng_rx_last) state_nx = ST_EXEC;
      ST_EXEC: begin
        if (!eng_busy) begin
          case (instr[15:8])
            OP_WRITE: state_nx = ST_FETCH;
            OP_WAIT:  state_nx = (instr[7:0] == 8'h00) ? ST_FETCH : ST_WAIT;
            OP_HALT:  state_nx = ST_HALT;
            default:  state_nx = ST_FAULT;
          endcase
        end
      end
      ST_WAIT:  if (cnt == 32'd0) state_nx = ST_FETCH;
      default:  state_nx = state;
    endcase
  end

  always_comb begin
    eng_start = 1'b0;
    eng_len   = BITS_FETCH;
    eng_tx    = '0;
    csb_nx    = 1'b1;
    case (state)
      ST_WAKE: begin
        eng_start = !launched && !eng_busy;
        eng_len   = BITS_WAKE;
        eng_tx    = {CMD_WAKE, 24'h000000};
      end
      ST_CMD: begin
        eng_start = !launched && !eng_busy;
        eng_len   = BITS_CMD;
        eng_tx    = {CMD_READ, 24'h000000};
      end
      ST_FETCH: eng_start = !launched && !eng_busy;
      default: ;
    endcase
    case (state_nx)
      ST_WAKE, ST_CMD, ST_FETCH, ST_EXEC, ST_WAIT: csb_nx = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      flash_csb <= 1'b1;
      launched  <= 1'b0;
      cnt       <= '0;
      instr     <= '0;
      pad       <= '0;
    end else begin
      flash_csb <= csb_nx;
      if (state_nx != state) launched <= 1'b0;
      else if (eng_start)    launched <= 1'b1;
      case (state)
        ST_WAKE: cnt <= '0;
        ST_GAP:  cnt <= cnt + 32'd1;
        ST_EXEC: cnt <= 32'(instr[7:0]) * WAIT_UNIT_W - 32'd1;
        ST_WAIT: cnt <= cnt - 32'd1;
        default: cnt <= cnt;
      endcase
      // The pad follows a WRITE the cycle after its operand's last bit is sampled.
      if (state == ST_FETCH && eng_rx_last) begin
        instr <= eng_rx;
        if (eng_rx[15:8] == OP_WRITE) pad <= eng_rx[7:0];
      end
    end
  end

  assign done        = (state == ST_HALT);
  assign fault       = (state == ST_FAULT);
  assign mprj_io_out = {30'b0, pad};
  assign mprj_io_oeb = PAD_OEB;

endmodule

// File: tb/tb_flash_io_sequencer.sv
// tb/tb_flash_io_sequencer.sv - three sequencers (CLK_DIV 2/1/4) against a behavioural SPI flash and program model
module tb_flash_io_sequencer;

  localparam int N = 3;
  localparam int LIMIT = 5000;
  localparam logic [37:0] OEB = 38'h3F_FFFF_FF00;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetb  [N];
  logic        csb     [N];
  logic        fclk    [N];
  logic        io0     [N];
  logic        io1     [N];
  logic [37:0] pout    [N];
  logic [37:0] poeb    [N];
  logic        done_o  [N];
  logic        fault_o [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    flash_io_sequencer #(.CLK_DIV(DIV), .WAKE_GAP(16), .WAIT_UNIT(256)) dut (
      .clock       (clock),
      .resetb      (resetb[g]),
      .flash_csb   (csb[g]),
      .flash_clk   (fclk[g]),
      .flash_io0   (io0[g]),
      .flash_io1   (io1[g]),
      .mprj_io_out (pout[g]),
      .mprj_io_oeb (poeb[g]),
      .done        (done_o[g]),
      .fault       (fault_o[g])
    );
  end

  logic [7:0]  mem [N][16];
  int          errs, checks, cyc;
  logic        pclk [N];
  logic        pcsb [N];
  int          sess_cnt [N], sess_bits [N], nbits [N], gap [N];
  int          period [N], first_rise [N], last_rise [N], maxgap [N];
  logic [7:0]  wake_sh [N];
  logic [31:0] cmd_sh [N];
  logic [7:0]  exp_pad [N];
  int          exp_term [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] byte_at(input int g, input int idx);
    return (idx < 16) ? mem[g][idx] : 8'hFF;
  endfunction

  // Program semantics: replay every instruction whose 16 bits have left the flash.
  // term: 0 running, 1 halted, 2 illegal opcode.
  function automatic void model(input int g, input int n, output logic [7:0] pad, output int term);
    logic [7:0] op, arg;
    pad  = 8'h00;
    term = 0;
    for (int i = 0; 16 * (i + 1) <= n && term == 0; i++) begin
      op  = byte_at(g, 2 * i);
      arg = byte_at(g, 2 * i + 1);
      if (op == 8'h01)      pad = arg;
      else if (op == 8'h00) term = 1;
      else if (op != 8'h02) term = 2;
    end
  endfunction

  task automatic cycle_check(input int g);
    logic [7:0] b;
    int idx;
    check("oeb", poeb[g], OEB);
    if (!resetb[g]) begin
      check("rst_csb", csb[g], 1'b1);
      check("rst_fclk", fclk[g], 1'b0);
      check("rst_io0", io0[g], 1'b0);
      check("rst_pads", pout[g], 38'h0);
      check("rst_done", done_o[g], 1'b0);
      check("rst_fault", fault_o[g], 1'b0);
      pclk[g] = 1'b0; pcsb[g] = 1'b1; io1[g] = 1'b0;
      sess_cnt[g] = 0; sess_bits[g] = 0; nbits[g] = 0; gap[g] = 0;
      period[g] = 0; first_rise[g] = 0; last_rise[g] = -1; maxgap[g] = 0;
      wake_sh[g] = 8'h00; cmd_sh[g] = 32'h0;
      exp_pad[g] = 8'h00; exp_term[g] = 0;
    end else begin
      check("pads", pout[g], {30'b0, exp_pad[g]});
      check("done_fault_excl", done_o[g] & fault_o[g], 1'b0);
      if (done_o[g])  check("done_needs_halt", exp_term[g], 1);
      if (fault_o[g]) check("fault_needs_illegal", exp_term[g], 2);
      if (pcsb[g] && !csb[g]) begin
        sess_cnt[g]++;
        sess_bits[g] = 0;
        last_rise[g] = -1;
      end
      if (csb[g] && sess_cnt[g] == 1) gap[g]++;
      if (!csb[g] && !pclk[g] && fclk[g]) begin
        if (sess_cnt[g] == 1 && sess_bits[g] < 8) wake_sh[g] = {wake_sh[g][6:0], io0[g]};
        if (sess_cnt[g] == 2) begin
          if (sess_bits[g] < 32) cmd_sh[g] = {cmd_sh[g][30:0], io0[g]};
          if (sess_bits[g] == 0) first_rise[g] = cyc;
          if (sess_bits[g] == 1) period[g] = cyc - first_rise[g];
          if (sess_bits[g] >= 32 && cmd_sh[g] == 32'h0300_0000) begin
            nbits[g]++;
            if (last_rise[g] >= 0 && cyc - last_rise[g] > maxgap[g]) maxgap[g] = cyc - last_rise[g];
            last_rise[g] = cyc;
          end
        end
        sess_bits[g]++;
      end
      if (!csb[g] && pclk[g] && !fclk[g] && sess_cnt[g] == 2 && sess_bits[g] >= 32 && cmd_sh[g] == 32'h0300_0000) begin
        idx = sess_bits[g] - 32;
        b = byte_at(g, idx / 8);
        io1[g] = b[7 - (idx % 8)];
      end
      pclk[g] = fclk[g];
      pcsb[g] = csb[g];
      model(g, nbits[g], exp_pad[g], exp_term[g]);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    for (int g = 0; g < N; g++) cycle_check(g);
  endtask

  task automatic load_prog(input int g, input logic [63:0] p);
    for (int i = 0; i < 16; i++) mem[g][i] = (i < 8) ? p[63 - 8 * i -: 8] : 8'hFF;
  endtask

  task automatic restart(input int g, input logic [63:0] p);
    resetb[g] = 1'b0;
    tick();
    load_prog(g, p);
    tick();
    resetb[g] = 1'b1;
  endtask

  task automatic wait_term(input int g);
    for (int i = 0; i < LIMIT; i++) begin
      if (done_o[g] || fault_o[g]) break;
      tick();
    end
    check("terminal_reached", done_o[g] | fault_o[g], 1'b1);
  endtask

  task automatic wait_pad(input int g, input logic [7:0] v);
    for (int i = 0; i < LIMIT; i++) begin
      if (pout[g][7:0] == v) break;
      tick();
    end
    check("pad_reached", pout[g][7:0], v);
  endtask

  int t1, t2;

  initial begin
    errs = 0; checks = 0; cyc = 0;
    for (int g = 0; g < N; g++) begin
      resetb[g] = 1'b0;
      io1[g]    = 1'b0;
      load_prog(g, 64'h01A5_0000_FFFF_FFFF);
    end
    repeat (3) tick();
    check("reset_csb_lit", csb[0], 1'b1);
    check("reset_pads_lit", pout[0], 38'h0);
    for (int g = 0; g < N; g++) resetb[g] = 1'b1;
    tick();
    check("first_csb_fall", csb[0], 1'b0);
    check("first_mosi_bit", io0[0], 1'b1);

    // Program 01 A5 00 00 on all three clock dividers
    wait_term(0);
    check("p1_pad", pout[0][7:0], 8'hA5);
    check("p1_done", done_o[0], 1'b1);
    check("p1_fault", fault_o[0], 1'b0);
    check("p1_csb", csb[0], 1'b1);
    check("p1_wake_byte", wake_sh[0], 8'hAB);
    check("p1_gap_ge16", gap[0] >= 16, 1'b1);
    check("p1_read_cmd", cmd_sh[0], 32'h0300_0000);
    check("p1_bits_read", nbits[0], 32);
    check("p1_period_div2", period[0], 4);
    wait_term(1);
    check("div1_pad", pout[1][7:0], 8'hA5);
    check("div1_done", done_o[1], 1'b1);
    check("div1_period", period[1], 2);
    wait_term(2);
    check("div4_pad", pout[2][7:0], 8'hA5);
    check("div4_done", done_o[2], 1'b1);
    check("div4_period", period[2], 8);

    // WAIT 4 stalls 1024 cycles between the two writes
    restart(0, 64'h0101_0204_0102_0000);
    wait_pad(0, 8'h01);
    t1 = cyc;
    wait_pad(0, 8'h02);
    t2 = cyc;
    check("p2_stall_ge1024", (t2 - t1) >= 1024, 1'b1);
    wait_term(0);
    check("p2_done", done_o[0], 1'b1);
    check("p2_pad", pout[0][7:0], 8'h02);
    check("p2_fclk_static", maxgap[0] >= 1024, 1'b1);

    // Erased flash faults on the first fetch
    restart(0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_term(0);
    check("p3_fault", fault_o[0], 1'b1);
    check("p3_done", done_o[0], 1'b0);
    check("p3_pad", pout[0][7:0], 8'h00);
    check("p3_csb", csb[0], 1'b1);
    check("p3_bits_read", nbits[0], 16);

    // Illegal opcode after a write keeps the pad value
    restart(0, 64'h013C_0700_FFFF_FFFF);
    wait_term(0);
    check("p4_fault", fault_o[0], 1'b1);
    check("p4_pad", pout[0][7:0], 8'h3C);
    check("p4_bits_read", nbits[0], 32);

    // Reset pulsed during the second fetch, then a full rerun
    restart(0, 64'h01A5_0000_FFFF_FFFF);
    for (int i = 0; i < LIMIT; i++) begin
      if (nbits[0] >= 20) break;
      tick();
    end
    check("p5_in_second_fetch", nbits[0] >= 20 && nbits[0] < 32, 1'b1);
    #2;
    resetb[0] = 1'b0;
    #1;
    check("p5_async_csb", csb[0], 1'b1);
    check("p5_async_pads", pout[0], 38'h0);
    check("p5_async_done", done_o[0], 1'b0);
    check("p5_async_fclk", fclk[0], 1'b0);
    tick();
    tick();
    resetb[0] = 1'b1;
    wait_term(0);
    check("p5_wake_byte", wake_sh[0], 8'hAB);
    check("p5_read_cmd", cmd_sh[0], 32'h0300_0000);
    check("p5_pad", pout[0][7:0], 8'hA5);
    check("p5_done", done_o[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
